// File: rtl/vloop_seq_pkg.sv
// Shared constants for the matmul loop sequencer: FSM encodings, default widths
// and the loop-level indices used to address the counter bank.
package vloop_seq_pkg;

  localparam int IDX_W_DEF = 32;
  localparam int OFF_W_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Counter bank order: innermost loop first so each level's increment is
  // the fire qualified by the wrap of every level below it.
  localparam int LVL_J   = 0;
  localparam int LVL_K   = 1;
  localparam int LVL_I   = 2;
  localparam int NUM_LVL = 3;

  function automatic logic [1:0] state_after_start(input logic any_zero);
    return any_zero ? ST_DONE : ST_ISSUE;
  endfunction

endpackage

// File: rtl/vloop_seq_if.sv
// Triple bus from the loop sequencer to the matmul datapath: indices, word
// offsets and loop-wrap flags behind a valid/ready handshake.
interface vloop_seq_if
  import vloop_seq_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int OFF_W = OFF_W_DEF
) ();

  logic             idx_valid;
  logic             idx_ready;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] j;
  logic [IDX_W-1:0] k;
  logic [OFF_W-1:0] off_a;
  logic [OFF_W-1:0] off_b;
  logic [OFF_W-1:0] off_c;
  logic             first_k;
  logic             last_j;
  logic             last_k;
  logic             last;

  modport master (
    output idx_valid, i, j, k, off_a, off_b, off_c,
    output first_k, last_j, last_k, last,
    input  idx_ready
  );

  modport slave (
    input  idx_valid, i, j, k, off_a, off_b, off_c,
    input  first_k, last_j, last_k, last,
    output idx_ready
  );

endinterface

// File: rtl/vloop_seq_vidx_counter.sv
// One loop index: counts 0..limit-1 on inc and wraps back to 0, flagging the
// wrap so the next-outer level can advance.
module vloop_seq_vidx_counter
  import vloop_seq_pkg::*;
#(
  parameter int W = IDX_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] val,
  output logic         is_last,
  output logic         wrap
);

  logic [W-1:0] val_reg;
  logic [W-1:0] val_next;

  assign is_last = (val_reg == (limit - W'(1)));
  assign wrap    = inc & is_last;
  assign val     = val_reg;

  always_comb begin
    val_next = val_reg;
    if (clr || wrap) begin
      val_next = '0;
    end else if (inc) begin
      val_next = val_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_reg <= '0;
    end else begin
      val_reg <= val_next;
    end
  end

endmodule

// File: rtl/vloop_seq.sv
// Matmul loop sequencer: walks i/k/j over the latched shape and issues one
// (i,j,k) triple per handshake with incrementally maintained A/B/C offsets.
module vloop_seq
  import vloop_seq_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] num_i,
  input  logic [IDX_W-1:0] num_j,
  input  logic [IDX_W-1:0] num_k,
  vloop_seq_if.master      idx,
  output logic             busy,
  output logic             done,
  output logic             err_zero
);

  logic [1:0]       state_reg, state_next;
  logic             err_reg, err_next;
  logic [IDX_W-1:0] ni_reg, ni_next;
  logic [IDX_W-1:0] nj_reg, nj_next;
  logic [IDX_W-1:0] nk_reg, nk_next;

  logic [OFF_W-1:0] off_a_reg, off_a_next;
  logic [OFF_W-1:0] off_b_reg, off_b_next;
  logic [OFF_W-1:0] off_c_reg, off_c_next;
  logic [OFF_W-1:0] ra_reg, ra_next;
  logic [OFF_W-1:0] rb_reg, rb_next;
  logic [OFF_W-1:0] rc_reg, rc_next;

  logic [IDX_W-1:0]   lim_arr [NUM_LVL];
  logic [IDX_W-1:0]   cnt_arr [NUM_LVL];
  logic [NUM_LVL-1:0] inc_vec;
  logic [NUM_LVL-1:0] last_vec;
  logic [NUM_LVL-1:0] wrap_vec;

  logic             valid;
  logic             fire;
  logic             any_zero;
  logic             start_ok;
  logic             cnt_clr;
  logic [OFF_W-1:0] nj_off;
  logic [OFF_W-1:0] nk_off;

  assign valid    = (state_reg == ST_ISSUE);
  assign fire     = valid & idx.idx_ready & ~abort;
  assign any_zero = (num_i == '0) | (num_j == '0) | (num_k == '0);
  assign start_ok = (state_reg == ST_IDLE) & start & ~abort & ~any_zero;
  assign cnt_clr  = abort | start_ok;
  assign nj_off   = OFF_W'(nj_reg);
  assign nk_off   = OFF_W'(nk_reg);

  assign lim_arr[LVL_J] = nj_reg;
  assign lim_arr[LVL_K] = nk_reg;
  assign lim_arr[LVL_I] = ni_reg;

  // Increments derive from is_last (pure register decode), never from wrap,
  // so the ripple between levels stays free of combinational feedback.
  assign inc_vec[LVL_J] = fire;
  assign inc_vec[LVL_K] = fire & last_vec[LVL_J];
  assign inc_vec[LVL_I] = fire & last_vec[LVL_J] & last_vec[LVL_K];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LVL; gi++) begin : g_cnt
      vloop_seq_vidx_counter #(
        .W(IDX_W)
      ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (inc_vec[gi]),
        .limit   (lim_arr[gi]),
        .val     (cnt_arr[gi]),
        .is_last (last_vec[gi]),
        .wrap    (wrap_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    ni_next    = ni_reg;
    nj_next    = nj_reg;
    nk_next    = nk_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next = state_after_start(any_zero);
            err_next   = any_zero;
            if (!any_zero) begin
              ni_next = num_i;
              nj_next = num_j;
              nk_next = num_k;
            end
          end
        end
        ST_ISSUE: begin
          if (wrap_vec[LVL_I]) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Row bases ra=i*num_k, rb=k*num_j, rc=i*num_j let every offset move by an
  // add of 1 or of a latched dimension; the final fire parks everything at 0.
  always_comb begin
    off_a_next = off_a_reg;
    off_b_next = off_b_reg;
    off_c_next = off_c_reg;
    ra_next    = ra_reg;
    rb_next    = rb_reg;
    rc_next    = rc_reg;
    if (abort || start_ok || wrap_vec[LVL_I]) begin
      off_a_next = '0;
      off_b_next = '0;
      off_c_next = '0;
      ra_next    = '0;
      rb_next    = '0;
      rc_next    = '0;
    end else if (fire) begin
      if (wrap_vec[LVL_K]) begin
        ra_next    = ra_reg + nk_off;
        rc_next    = rc_reg + nj_off;
        rb_next    = '0;
        off_a_next = ra_reg + nk_off;
        off_b_next = '0;
        off_c_next = rc_reg + nj_off;
      end else if (wrap_vec[LVL_J]) begin
        rb_next    = rb_reg + nj_off;
        off_a_next = off_a_reg + OFF_W'(1);
        off_b_next = rb_reg + nj_off;
        off_c_next = rc_reg;
      end else begin
        off_b_next = off_b_reg + OFF_W'(1);
        off_c_next = off_c_reg + OFF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      err_reg   <= 1'b0;
      ni_reg    <= '0;
      nj_reg    <= '0;
      nk_reg    <= '0;
      off_a_reg <= '0;
      off_b_reg <= '0;
      off_c_reg <= '0;
      ra_reg    <= '0;
      rb_reg    <= '0;
      rc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      ni_reg    <= ni_next;
      nj_reg    <= nj_next;
      nk_reg    <= nk_next;
      off_a_reg <= off_a_next;
      off_b_reg <= off_b_next;
      off_c_reg <= off_c_next;
      ra_reg    <= ra_next;
      rb_reg    <= rb_next;
      rc_reg    <= rc_next;
    end
  end

  assign idx.idx_valid = valid;
  assign idx.i         = cnt_arr[LVL_I];
  assign idx.j         = cnt_arr[LVL_J];
  assign idx.k         = cnt_arr[LVL_K];
  assign idx.off_a     = off_a_reg;
  assign idx.off_b     = off_b_reg;
  assign idx.off_c     = off_c_reg;
  assign idx.first_k   = valid & (cnt_arr[LVL_K] == '0);
  assign idx.last_j    = valid & last_vec[LVL_J];
  assign idx.last_k    = valid & last_vec[LVL_K];
  assign idx.last      = valid & (&last_vec);

  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign err_zero = err_reg & (state_reg == ST_DONE);

endmodule
